bc_ctrl_seq: RTL and testbench

//  Parametrised control sequencer for the basic computer. It replaces the fixed T0..T3 timing-signal controller with an

---
 rtl/bc_ctrl_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_bc_ctrl_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bc_ctrl_seq.sv
// Control sequencer for the basic computer: an explicit fetch/decode/execute FSM.
// Memory accesses use a ready handshake, and the FSM drives bus select and one-cycle micro-op strobes.
//
// state | meaning
// F0    | AR <- PC
// F1    | read instruction; IR <- M[AR], PC++ when mem_ready
// DEC   | AR <- IR address field; latch opcode and dispatch
// IND   | indirect: AR <- M[AR] when mem_ready
// RD    | operand read: DR <- M[AR] when mem_ready
// EX1   | ALU op / ISZ increment / BUN jump / register-reference action
// EX2A  | BSA: AR++
// EX2B  | BSA: PC <- AR
// WR    | memory write (STA: AC, BSA: PC, ISZ: DR)
// HALT  | stopped until reset
module bc_ctrl_seq #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = WIDTH - 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ir,
    input  logic             dr_zero,
    input  logic             ac_sign,
    input  logic             ac_zero,
    input  logic             e_flag,
    input  logic             mem_ready,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [2:0]       bus_sel,
    output logic             ld_ar,
    output logic             inr_ar,
    output logic             ld_pc,
    output logic             inr_pc,
    output logic             ld_ir,
    output logic             ld_dr,
    output logic             inr_dr,
    output logic [2:0]       alu_op,
    output logic             clr_ac,
    output logic             clr_e,
    output logic             cmp_e,
    output logic             halted
);

    typedef enum logic [3:0] {
        S_F0, S_F1, S_DEC, S_IND, S_RD, S_EX1, S_EX2A, S_EX2B, S_WR, S_HALT
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3,
                           OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_REG = 3'd7;

    localparam logic [2:0] BUS_NONE = 3'b000, BUS_PC = 3'b001, BUS_AR = 3'b010, BUS_DR = 3'b011,
                           BUS_IR = 3'b100, BUS_AC = 3'b101, BUS_MEM = 3'b110;

    localparam logic [2:0] ALU_NONE = 3'b000, ALU_AND = 3'b001, ALU_ADD = 3'b010, ALU_PASS = 3'b011,
                           ALU_CMA = 3'b100, ALU_CIR = 3'b101, ALU_CIL = 3'b110, ALU_INC = 3'b111;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       halted_q;
    logic [11:0] rr_bits;
    logic [2:0]  ir_op;

    // Register-reference field: the top 12 bits of the address field.
    assign rr_bits = ir[ADDR_W-1 -: 12];
    assign ir_op   = ir[WIDTH-2:WIDTH-4];

    function automatic state_t dispatch(input logic [2:0] op);
        case (op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: dispatch = S_RD;
            OP_STA, OP_BSA:                 dispatch = S_WR;
            default:                        dispatch = S_EX1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_F0;
            op_q     <= OP_AND;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            halted_q <= (state_d == S_HALT);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        bus_sel = BUS_NONE;
        ld_ar   = 1'b0;
        inr_ar  = 1'b0;
        ld_pc   = 1'b0;
        inr_pc  = 1'b0;
        ld_ir   = 1'b0;
        ld_dr   = 1'b0;
        inr_dr  = 1'b0;
        alu_op  = ALU_NONE;
        clr_ac  = 1'b0;
        clr_e   = 1'b0;
        cmp_e   = 1'b0;

        case (state_q)
            S_F0: begin
                bus_sel = BUS_PC;
                ld_ar   = 1'b1;
                state_d = S_F1;
            end
            S_F1: begin
                mem_rd  = 1'b1;
                bus_sel = BUS_MEM;
                if (mem_ready) begin
                    ld_ir   = 1'b1;
                    inr_pc  = 1'b1;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                bus_sel = BUS_IR;
                ld_ar   = 1'b1;
                op_d    = ir_op;
                if (ir_op == OP_REG)  state_d = S_EX1;
                else if (ir[WIDTH-1]) state_d = S_IND;
                else                  state_d = dispatch(ir_op);
            end
            S_IND: begin
                mem_rd  = 1'b1;
                bus_sel = BUS_MEM;
                if (mem_ready) begin
                    ld_ar   = 1'b1;
                    state_d = dispatch(op_q);
                end
            end
            S_RD: begin
                mem_rd  = 1'b1;
                bus_sel = BUS_MEM;
                if (mem_ready) begin
                    ld_dr   = 1'b1;
                    state_d = S_EX1;
                end
            end
            S_EX1: begin
                state_d = S_F0;
                case (op_q)
                    OP_AND: alu_op = ALU_AND;
                    OP_ADD: alu_op = ALU_ADD;
                    OP_LDA: alu_op = ALU_PASS;
                    OP_ISZ: begin
                        inr_dr  = 1'b1;
                        state_d = S_WR;
                    end
                    OP_BUN: begin
                        bus_sel = BUS_AR;
                        ld_pc   = 1'b1;
                    end
                    OP_REG: begin
                        // Only the highest set bit acts.
                        if      (rr_bits[11]) clr_ac = 1'b1;
                        else if (rr_bits[10]) clr_e  = 1'b1;
                        else if (rr_bits[9])  alu_op = ALU_CMA;
                        else if (rr_bits[8])  cmp_e  = 1'b1;
                        else if (rr_bits[7])  alu_op = ALU_CIR;
                        else if (rr_bits[6])  alu_op = ALU_CIL;
                        else if (rr_bits[5])  alu_op = ALU_INC;
                        else if (rr_bits[4])  inr_pc = !ac_sign && !ac_zero;
                        else if (rr_bits[3])  inr_pc = ac_sign;
                        else if (rr_bits[2])  inr_pc = ac_zero;
                        else if (rr_bits[1])  inr_pc = !e_flag;
                        else if (rr_bits[0])  state_d = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_EX2A: begin
                inr_ar  = 1'b1;
                state_d = S_EX2B;
            end
            S_EX2B: begin
                bus_sel = BUS_AR;
                ld_pc   = 1'b1;
                state_d = S_F0;
            end
            S_WR: begin
                mem_wr = 1'b1;
                if (op_q == OP_ISZ)      bus_sel = BUS_DR;
                else if (op_q == OP_BSA) bus_sel = BUS_PC;
                else                     bus_sel = BUS_AC;
                if (mem_ready) begin
                    inr_pc  = (op_q == OP_ISZ) && dr_zero;
                    state_d = (op_q == OP_BSA) ? S_EX2A : S_F0;
                end
            end
            S_HALT: ;
            default: state_d = S_F0;
        endcase

        // Strobes are combinational, so they must be forced quiet while reset is held.
        if (!rst_n) begin
            mem_rd  = 1'b0;
            mem_wr  = 1'b0;
            bus_sel = BUS_NONE;
            ld_ar   = 1'b0;
            inr_ar  = 1'b0;
            ld_pc   = 1'b0;
            inr_pc  = 1'b0;
            ld_ir   = 1'b0;
            ld_dr   = 1'b0;
            inr_dr  = 1'b0;
            alu_op  = ALU_NONE;
            clr_ac  = 1'b0;
            clr_e   = 1'b0;
            cmp_e   = 1'b0;
        end
    end

    assign halted = halted_q;

endmodule

// File: tb/tb_bc_ctrl_seq.sv
// Directed bench for bc_ctrl_seq: per-cycle output vectors compared against hand-derived expectations.
module tb_bc_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir;
    logic        dr_zero, ac_sign, ac_zero, e_flag, mem_ready;
    logic        mem_rd, mem_wr, ld_ar, inr_ar, ld_pc, inr_pc, ld_ir, ld_dr, inr_dr;
    logic        clr_ac, clr_e, cmp_e, halted;
    logic [2:0]  bus_sel, alu_op;
    logic [18:0] obs;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bc_ctrl_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .dr_zero(dr_zero), .ac_sign(ac_sign),
        .ac_zero(ac_zero), .e_flag(e_flag), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .bus_sel(bus_sel), .ld_ar(ld_ar),
        .inr_ar(inr_ar), .ld_pc(ld_pc), .inr_pc(inr_pc), .ld_ir(ld_ir), .ld_dr(ld_dr),
        .inr_dr(inr_dr), .alu_op(alu_op), .clr_ac(clr_ac), .clr_e(clr_e),
        .cmp_e(cmp_e), .halted(halted)
    );

    // Observation vector layout: rd wr bus[3] ld_ar inr_ar ld_pc inr_pc ld_ir ld_dr inr_dr alu[3] clr_ac clr_e cmp_e halted
    assign obs = {mem_rd, mem_wr, bus_sel, ld_ar, inr_ar, ld_pc, inr_pc, ld_ir, ld_dr,
                  inr_dr, alu_op, clr_ac, clr_e, cmp_e, halted};

    localparam logic [18:0] RD    = 19'(1) << 18;
    localparam logic [18:0] WR    = 19'(1) << 17;
    localparam logic [18:0] B_PC  = 19'(1) << 14;
    localparam logic [18:0] B_AR  = 19'(2) << 14;
    localparam logic [18:0] B_DR  = 19'(3) << 14;
    localparam logic [18:0] B_IR  = 19'(4) << 14;
    localparam logic [18:0] B_AC  = 19'(5) << 14;
    localparam logic [18:0] B_MEM = 19'(6) << 14;
    localparam logic [18:0] LAR   = 19'(1) << 13;
    localparam logic [18:0] IAR   = 19'(1) << 12;
    localparam logic [18:0] LPC   = 19'(1) << 11;
    localparam logic [18:0] IPC   = 19'(1) << 10;
    localparam logic [18:0] LIR   = 19'(1) << 9;
    localparam logic [18:0] LDR   = 19'(1) << 8;
    localparam logic [18:0] IDR   = 19'(1) << 7;
    localparam logic [18:0] A_ADD = 19'(2) << 4;
    localparam logic [18:0] A_LDA = 19'(3) << 4;
    localparam logic [18:0] A_CIL = 19'(6) << 4;
    localparam logic [18:0] CAC   = 19'(1) << 3;
    localparam logic [18:0] HLT   = 19'(1);
    localparam logic [18:0] NONE  = 19'(0);

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [18:0] exp);
        @(negedge clk);
        chk(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_dec(input string tag);
        cyc({tag, "_f0"}, B_PC | LAR);
        cyc({tag, "_f1"}, RD | B_MEM | LIR | IPC);
        cyc({tag, "_dec"}, B_IR | LAR);
    endtask

    initial begin
        rst_n = 1'b0; ir = 16'h2005; dr_zero = 1'b0; ac_sign = 1'b0;
        ac_zero = 1'b0; e_flag = 1'b0; mem_ready = 1'b1;
        #2;
        chk("reset_quiet", obs, NONE);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // LDA direct, ready tied high
        fetch_dec("lda");
        cyc("lda_rd", RD | B_MEM | LDR);
        cyc("lda_ex1", A_LDA);

        // LDA with three wait states in F1
        cyc("ldaw_f0", B_PC | LAR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ldaw_f1_wait", RD | B_MEM);
        mem_ready = 1'b1;
        cyc("ldaw_f1_rdy", RD | B_MEM | LIR | IPC);
        cyc("ldaw_dec", B_IR | LAR);
        cyc("ldaw_rd", RD | B_MEM | LDR);
        cyc("ldaw_ex1", A_LDA);

        // ADD indirect
        ir = 16'h9010;
        fetch_dec("addi");
        cyc("addi_ind", RD | B_MEM | LAR);
        cyc("addi_rd", RD | B_MEM | LDR);
        cyc("addi_ex1", A_ADD);

        // ISZ with DR reaching zero, then not
        ir = 16'h6020; dr_zero = 1'b1;
        fetch_dec("isz1");
        cyc("isz1_rd", RD | B_MEM | LDR);
        cyc("isz1_ex1", IDR);
        cyc("isz1_wr", WR | B_DR | IPC);
        dr_zero = 1'b0;
        fetch_dec("isz0");
        cyc("isz0_rd", RD | B_MEM | LDR);
        cyc("isz0_ex1", IDR);
        cyc("isz0_wr", WR | B_DR);

        // STA with one write wait state
        ir = 16'h3011;
        fetch_dec("sta");
        mem_ready = 1'b0;
        cyc("sta_wr_wait", WR | B_AC);
        mem_ready = 1'b1;
        cyc("sta_wr", WR | B_AC);

        // BSA
        ir = 16'h5010;
        fetch_dec("bsa");
        cyc("bsa_wr", WR | B_PC);
        cyc("bsa_ex2a", IAR);
        cyc("bsa_ex2b", B_AR | LPC);

        // BUN
        ir = 16'h4012;
        fetch_dec("bun");
        cyc("bun_ex1", B_AR | LPC);

        // Register-reference priority and skips
        ir = 16'h7A00;
        fetch_dec("cla");
        cyc("cla_ex1", CAC);
        ir = 16'h7050;
        fetch_dec("cil");
        cyc("cil_ex1", A_CIL);
        ir = 16'h7010;
        fetch_dec("spa");
        cyc("spa_ex1", IPC);
        ac_zero = 1'b1;
        fetch_dec("spaz");
        cyc("spaz_ex1", NONE);
        ac_zero = 1'b0;

        // HLT, with mem_ready toggling to confirm it is ignored
        ir = 16'h7001;
        fetch_dec("hlt");
        cyc("hlt_ex1", NONE);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            cyc("hlt_hold", HLT);
        end
        mem_ready = 1'b1;

        // Reset out of HALT
        rst_n = 1'b0;
        #1 chk("rst_from_halt", obs, NONE);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ir = 16'h2005; mem_ready = 1'b0;
        cyc("rst1_f0", B_PC | LAR);

        // Reset in the middle of a read
        @(negedge clk);
        chk("rst_mid_f1_rd", obs, RD | B_MEM);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_drop", obs, NONE);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ready = 1'b1;
        cyc("rst2_f0", B_PC | LAR);
        cyc("rst2_f1", RD | B_MEM | LIR | IPC);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
